up_sample2x: RTL and testbench
==============================

// Module: up_sample2x
// PURPOSE
//  2x2 nearest-neighbour up-sampler. It is the inverse of the 2x2 max-pool stage.
//  - Reads a pooled int8 feature map from block RAM, one input row at a time.
//  - Writes each element into a 2x2 output patch in a second RAM region.
//  - Used on the decoder/expansion path to rebuild 48x48 maps from 24x24 maps.
// PARAMETERS
//  ifmap_h  24  input rows per channel
//  ifmap_w  24  input columns (IW); output row width OW = 2*IW
//  ifmap_c  8   channels; total input rows R = ifmap_h*ifmap_c
//  RD_LAT   2   RAM read latency in cycles; legal values 1..3
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   synchronous, active-HIGH reset (name per codebase)
//  start_US    in   1   start pulse; sampled only in IDLE
//  end_US      out  1   done flag; high for exactly 4 cycles
//  ram_addr_r  out  16  read address, input map, linear base 0
//  ram_data_r  in   8   read data; valid RD_LAT cycles after its address
//  ram_en_r    out  1   read enable
//  ram_addr_w  out  16  write address, output map, linear base 0
//  ram_data_w  out  8   write data
//  ram_en      out  1   write port enable
//  ram_wea     out  1   write strobe
// BEHAVIOUR
//  - Reset: all outputs 0, FSM to IDLE, row counter r=0, beat counter k=0.
//    Applies even mid-operation; the next cycle behaves as post-reset.
//  - Layout: input row r (0..R-1) occupies addresses r*IW .. r*IW+IW-1.
//    It maps to output rows 2r and 2r+1, at 2r*OW+j and (2r+1)*OW+j.
//  - FSM states: IDLE -> READ -> WR_A -> WR_B -> (READ | DONE) -> IDLE.
//  - IDLE: outputs 0. start_US=1 -> READ next cycle, with r=0.
//  - READ: lasts IW+RD_LAT cycles, k=0..IW+RD_LAT-1.
//    - k<IW: ram_en_r=1, ram_addr_r=r*IW+k. Else ram_en_r=0 and ram_addr_r holds.
//    - k>=RD_LAT: rowbuf[k-RD_LAT] <= ram_data_r.
//  - WR_A: lasts 2*IW cycles, j=0..2*IW-1.
//    - ram_en=ram_wea=1, ram_addr_w=2r*OW+j, ram_data_w=rowbuf[j>>1].
//  - WR_B: same as WR_A, but ram_addr_w=(2r+1)*OW+j.
//  - After WR_B:
//    - r<R-1: r<=r+1, go to READ.
//    - else go to DONE.
//  - DONE: end_US=1 for 4 cycles, then IDLE with r=0. All RAM enables are 0.
//  - Enables and strobes are 0 in every cycle not listed above. No write beat is skipped or repeated.
//  - ram_data_w is a byte-exact copy; the sign is never interpreted.
//    Addresses are unsigned 16-bit and must not wrap: R*IW*4 <= 65536.
//  - start_US is ignored outside IDLE, including in DONE.
//    A start held high across DONE->IDLE starts a new pass from r=0.
//  - Cycles from start sample to DONE entry: R*(IW+RD_LAT+4*IW).
//    Default: 192*122 = 23424.
//  - rowbuf: IW x 8-bit registers, no reset required.
//    Never read before being written in the current row.
// TESTING
//  1. Tiny map, ifmap_h=2, ifmap_w=4, ifmap_c=1; input RAM 0..7.
//     - addr 0-7 and 8-15 = 0,0,1,1,2,2,3,3.
//     - addr 16-23 and 24-31 = 4,4,5,5,6,6,7,7.
//     - end_US high 4 cycles.
//  2. Extremes: inputs 0x80,0x7F,0x00,0xFF -> written bytes identical, no sign or ordering change.
//  3. Default config full run.
//     - 4608 reads, last ram_addr_r=4607.
//     - 18432 write beats, last ram_addr_w=18431.
//     - DONE entered 23424 cycles after start.
//  4. Reset mid-op: rst_n=1 for 1 cycle during WR_A of row 5.
//     - Next cycle: all outputs 0, IDLE.
//     - A fresh start rewrites from addr 0.
//  5. start_US pulsed during READ, WR_B and DONE -> ignored.
//     A start 1 cycle after return to IDLE -> second pass identical to the first.
//  6. RD_LAT=1 and RD_LAT=3 with a latency-matched RAM model.
//     - Output identical to test 1.
//     - READ length = IW+RD_LAT cycles.

Source files
------------

// File: rtl/up_sample2x_if.sv
// up_sample2x_if: control handshake plus read/write RAM ports of the up-sampler.
// master = up-sampler side, slave = RAM / controller side.
interface up_sample2x_if;
   logic        start_US;
   logic        end_US;
   logic [15:0] ram_addr_r;
   logic [7:0]  ram_data_r;
   logic        ram_en_r;
   logic [15:0] ram_addr_w;
   logic [7:0]  ram_data_w;
   logic        ram_en;
   logic        ram_wea;

   modport master (
      input  start_US,
      input  ram_data_r,
      output end_US,
      output ram_addr_r,
      output ram_en_r,
      output ram_addr_w,
      output ram_data_w,
      output ram_en,
      output ram_wea
   );

   modport slave (
      output start_US,
      output ram_data_r,
      input  end_US,
      input  ram_addr_r,
      input  ram_en_r,
      input  ram_addr_w,
      input  ram_data_w,
      input  ram_en,
      input  ram_wea
   );
endinterface

// File: rtl/up_sample2x.sv
// up_sample2x: 2x2 nearest-neighbour up-sampler for int8 feature maps.
// Each input row is fetched into a row buffer, then written out twice
// (output rows 2r and 2r+1) with every byte duplicated horizontally.
// RAM outputs are decoded combinationally from the FSM state and counters.
module up_sample2x #(
   parameter int unsigned ifmap_h = 24,
   parameter int unsigned ifmap_w = 24,
   parameter int unsigned ifmap_c = 8,
   parameter int unsigned RD_LAT  = 2   // legal 1..3
) (
   input logic           clk,
   input logic           rst_n,         // synchronous, active high
   up_sample2x_if.master bus
);

   localparam int unsigned IW    = ifmap_w;
   localparam int unsigned OW    = 2 * ifmap_w;
   localparam int unsigned R     = ifmap_h * ifmap_c;
   localparam int unsigned IDX_W = (IW > 1) ? $clog2(IW) : 1;

   localparam logic [15:0] IW16       = 16'(IW);
   localparam logic [15:0] OW16       = 16'(OW);
   localparam logic [15:0] RD_LAT16   = 16'(RD_LAT);
   localparam logic [15:0] READ_LAST  = 16'(IW + RD_LAT - 1);
   localparam logic [15:0] WR_LAST    = 16'(OW - 1);
   localparam logic [15:0] DONE_LAST  = 16'd3;
   localparam logic [15:0] ROW_LAST   = 16'(R - 1);
   // One input row expands to two output rows: 4*IW output bytes.
   localparam logic [15:0] WR_STEP    = 16'(4 * IW);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] READ = 3'd1;
   localparam logic [2:0] WR_A = 3'd2;
   localparam logic [2:0] WR_B = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]  state_q,   state_d;
   logic [15:0] k_q,       k_d;        // beat counter within the current state
   logic [15:0] r_q,       r_d;        // input row index
   logic [15:0] rd_base_q, rd_base_d;  // r*IW
   logic [15:0] wr_base_q, wr_base_d;  // 2r*OW

   logic [7:0]  rowbuf [IW];

   logic [IDX_W-1:0] rb_wr_idx;
   logic [IDX_W-1:0] rb_rd_idx;
   logic             rb_we;

   logic        end_us;
   logic [15:0] addr_r;
   logic        en_r;
   logic [15:0] addr_w;
   logic [7:0]  data_w;
   logic        en_w;

   // Next-state, counter and row-base sequencing.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      r_d       = r_q;
      rd_base_d = rd_base_q;
      wr_base_d = wr_base_q;
      case (state_q)
         IDLE: begin
            if (bus.start_US) begin
               state_d   = READ;
               k_d       = 16'd0;
               r_d       = 16'd0;
               rd_base_d = 16'd0;
               wr_base_d = 16'd0;
            end
         end
         READ: begin
            if (k_q == READ_LAST) begin
               state_d = WR_A;
               k_d     = 16'd0;
            end else begin
               k_d = k_q + 16'd1;
            end
         end
         WR_A: begin
            if (k_q == WR_LAST) begin
               state_d = WR_B;
               k_d     = 16'd0;
            end else begin
               k_d = k_q + 16'd1;
            end
         end
         WR_B: begin
            if (k_q == WR_LAST) begin
               k_d = 16'd0;
               if (r_q == ROW_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d   = READ;
                  r_d       = r_q + 16'd1;
                  rd_base_d = rd_base_q + IW16;
                  wr_base_d = wr_base_q + WR_STEP;
               end
            end else begin
               k_d = k_q + 16'd1;
            end
         end
         DONE: begin
            if (k_q == DONE_LAST) begin
               state_d = IDLE;
               k_d     = 16'd0;
               r_d     = 16'd0;
            end else begin
               k_d = k_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = 16'd0;
            r_d     = 16'd0;
         end
      endcase
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= IDLE;
         k_q       <= 16'd0;
         r_q       <= 16'd0;
         rd_base_q <= 16'd0;
         wr_base_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         r_q       <= r_d;
         rd_base_q <= rd_base_d;
         wr_base_q <= wr_base_d;
      end
   end

   // Read data for beat k arrives RD_LAT beats later; lands in slot k-RD_LAT.
   assign rb_we     = (state_q == READ) && (k_q >= RD_LAT16);
   assign rb_wr_idx = IDX_W'(k_q - RD_LAT16);
   // Each buffered byte feeds two consecutive output columns.
   assign rb_rd_idx = IDX_W'(k_q >> 1);

   // Row buffer capture; no reset needed, every slot is refilled before use.
   always_ff @(posedge clk) begin
      if (rb_we) begin
         rowbuf[rb_wr_idx] <= bus.ram_data_r;
      end
   end

   // RAM port and done-flag decode.
   always_comb begin
      end_us = 1'b0;
      addr_r = 16'd0;
      en_r   = 1'b0;
      addr_w = 16'd0;
      data_w = 8'd0;
      en_w   = 1'b0;
      case (state_q)
         READ: begin
            if (k_q < IW16) begin
               en_r   = 1'b1;
               addr_r = rd_base_q + k_q;
            end else begin
               // Latency drain: address holds at the last element of the row.
               addr_r = rd_base_q + IW16 - 16'd1;
            end
         end
         WR_A: begin
            en_w   = 1'b1;
            addr_w = wr_base_q + k_q;
            data_w = rowbuf[rb_rd_idx];
         end
         WR_B: begin
            en_w   = 1'b1;
            addr_w = wr_base_q + OW16 + k_q;
            data_w = rowbuf[rb_rd_idx];
         end
         DONE: begin
            end_us = 1'b1;
         end
         default: begin
            end_us = 1'b0;
         end
      endcase
   end

   assign bus.end_US     = end_us;
   assign bus.ram_addr_r = addr_r;
   assign bus.ram_en_r   = en_r;
   assign bus.ram_addr_w = addr_w;
   assign bus.ram_data_w = data_w;
   assign bus.ram_en     = en_w;
   assign bus.ram_wea    = en_w;

endmodule

// File: tb/tb_up_sample2x.sv
// tb_up_sample2x: directed bench for up_sample2x.
// Four instances: tiny 2x4x1 map at RD_LAT 2/1/3, and the default 24x24x8 map.
module tb_up_sample2x;

   typedef struct packed {
      int unsigned n_rd;
      int unsigned n_wr;
      int unsigned last_ra;
      int unsigned last_wa;
      int unsigned seq_bad;
      int unsigned dbad;
      int unsigned en_bad;
      int unsigned n_end;
      int unsigned t_start;
      int unsigned t_done;
      int unsigned t_rd0;
      int unsigned t_wr0;
      logic        seen_start;
      logic        seen_done;
      logic        seen_rd;
      logic        seen_wr;
   } stats_t;

   // Output rows 0-1 / 2-3 of the tiny map; byte 0 is the least significant.
   localparam logic [63:0]  ROW_LO  = 64'h0303_0202_0101_0000;
   localparam logic [63:0]  ROW_HI  = 64'h0707_0606_0505_0404;
   localparam logic [255:0] EXP_T1  = {ROW_HI, ROW_HI, ROW_LO, ROW_LO};
   localparam logic [63:0]  XROW_LO = 64'hFFFF_0000_7F7F_8080;
   localparam logic [63:0]  XROW_HI = 64'h8080_7F7F_0000_FFFF;
   localparam logic [255:0] EXP_T2  = {XROW_HI, XROW_HI, XROW_LO, XROW_LO};

   logic       clk = 1'b0;
   logic       rst   [4];
   logic       start [4];
   logic       clr   [4];
   logic [7:0] tiny_in [8];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam bit          TINY = (g < 3);
      localparam int unsigned GH   = TINY ? 2 : 24;
      localparam int unsigned GW   = TINY ? 4 : 24;
      localparam int unsigned GC   = TINY ? 1 : 8;
      localparam int unsigned GL   = (g == 1) ? 1 : ((g == 2) ? 3 : 2);
      localparam int unsigned GOW  = 2 * GW;

      up_sample2x_if bus ();

      up_sample2x #(
         .ifmap_h (GH),
         .ifmap_w (GW),
         .ifmap_c (GC),
         .RD_LAT  (GL)
      ) dut (
         .clk   (clk),
         .rst_n (rst[g]),
         .bus   (bus)
      );

      function automatic logic [7:0] src(input int unsigned a);
         if (TINY) return tiny_in[a % 8];
         return 8'(a ^ (a >> 8));
      endfunction

      // Expected byte at output address a: nearest input element.
      function automatic logic [7:0] exp_wdata(input int unsigned a);
         int unsigned orow = a / GOW;
         int unsigned col  = a % GOW;
         return src((orow / 2) * GW + col / 2);
      endfunction

      logic [7:0]   pipe [3];
      logic [7:0]   omem [32];
      logic [255:0] omem_flat;
      logic [43:0]  outs;
      stats_t       st;
      int unsigned  cyc = 0;

      assign bus.start_US   = start[g];
      assign bus.ram_data_r = pipe[GL-1];
      assign outs = {bus.end_US, bus.ram_addr_r, bus.ram_en_r, bus.ram_addr_w,
                     bus.ram_data_w, bus.ram_en, bus.ram_wea};

      always_comb begin
         omem_flat = '0;
         for (int i = 0; i < 32; i++) omem_flat[i*8 +: 8] = omem[i];
      end

      // RAM with GL-cycle read latency; non-enabled reads return poison.
      always_ff @(posedge clk) begin
         pipe[0] <= bus.ram_en_r ? src(32'(bus.ram_addr_r)) : 8'hA5;
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end

      // Bus monitor: counts, ordering, data and timing.
      always_ff @(posedge clk) begin
         cyc <= cyc + 1;
         if (clr[g]) begin
            st <= '0;
         end else begin
            if (start[g] && !st.seen_start) begin
               st.seen_start <= 1'b1;
               st.t_start    <= cyc;
            end
            if (bus.ram_en_r) begin
               if (!st.seen_rd) begin
                  st.seen_rd <= 1'b1;
                  st.t_rd0   <= cyc;
               end
               if (32'(bus.ram_addr_r) != st.n_rd) st.seq_bad <= st.seq_bad + 1;
               st.n_rd    <= st.n_rd + 1;
               st.last_ra <= 32'(bus.ram_addr_r);
            end
            if (bus.ram_en || bus.ram_wea) begin
               if (!(bus.ram_en && bus.ram_wea)) st.en_bad <= st.en_bad + 1;
               if (!st.seen_wr) begin
                  st.seen_wr <= 1'b1;
                  st.t_wr0   <= cyc;
               end
               if (32'(bus.ram_addr_w) != st.n_wr) st.seq_bad <= st.seq_bad + 1;
               if (bus.ram_data_w != exp_wdata(32'(bus.ram_addr_w))) st.dbad <= st.dbad + 1;
               omem[bus.ram_addr_w[4:0]] <= bus.ram_data_w;
               st.n_wr    <= st.n_wr + 1;
               st.last_wa <= 32'(bus.ram_addr_w);
            end
            if (bus.end_US) begin
               st.n_end <= st.n_end + 1;
               if (!st.seen_done) begin
                  st.seen_done <= 1'b1;
                  st.t_done    <= cyc;
               end
               if (bus.ram_en_r || bus.ram_en || bus.ram_wea) st.en_bad <= st.en_bad + 1;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input longint unsigned got,
                           input longint unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // end_US is first seen one edge after DONE is entered, hence the -1.
   task automatic check_run(input string tag, input stats_t s, input int unsigned nin,
                            input int unsigned exp_delta, input int unsigned exp_rdlen);
      check_eq({tag, "_reads"},    s.n_rd, nin);
      check_eq({tag, "_last_ra"},  s.last_ra, nin - 1);
      check_eq({tag, "_writes"},   s.n_wr, 4 * nin);
      check_eq({tag, "_last_wa"},  s.last_wa, 4 * nin - 1);
      check_eq({tag, "_order"},    s.seq_bad, 0);
      check_eq({tag, "_data"},     s.dbad, 0);
      check_eq({tag, "_strobes"},  s.en_bad, 0);
      check_eq({tag, "_end_len"},  s.n_end, 4);
      check_eq({tag, "_done_cyc"}, s.t_done - s.t_start - 1, exp_delta);
      check_eq({tag, "_read_len"}, s.t_wr0 - s.t_rd0, exp_rdlen);
   endtask

   task automatic check_map(input string tag, input logic [255:0] got,
                            input logic [255:0] exp);
      for (int i = 0; i < 32; i++)
         check_eq($sformatf("%s_addr%0d", tag, i), got[i*8 +: 8], exp[i*8 +: 8]);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rst[i]   = 1'b1;
         start[i] = 1'b0;
         clr[i]   = 1'b1;
      end
      for (int i = 0; i < 8; i++) tiny_in[i] = 8'(i);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b0;
         clr[i] = 1'b0;
      end
      @(negedge clk);
      check_eq("reset_outs_g0", g_dut[0].outs, 0);
      check_eq("reset_outs_g3", g_dut[3].outs, 0);

      // Tiny map at all three latencies; stray starts on instance 0.
      start[0] = 1'b1; start[1] = 1'b1; start[2] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0;
      for (int i = 0; i < 20 && !g_dut[0].bus.ram_en_r; i++) @(negedge clk);
      check_eq("t5_in_read", g_dut[0].bus.ram_en_r, 1);
      start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
      for (int i = 0; i < 100 && !(g_dut[0].bus.ram_en && g_dut[0].bus.ram_addr_w[15:3] == 13'd1);
           i++) @(negedge clk);
      check_eq("t5_in_wr_b", g_dut[0].bus.ram_addr_w[15:3], 1);
      start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
      for (int i = 0; i < 100 && !g_dut[0].bus.end_US; i++) @(negedge clk);
      check_eq("t5_in_done", g_dut[0].bus.end_US, 1);
      start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
      for (int i = 0; i < 10 && g_dut[0].bus.end_US; i++) @(negedge clk);
      check_eq("t5_back_idle", g_dut[0].outs, 0);
      check_run("t1", g_dut[0].st, 8, 44, 6);
      check_map("t1_map", g_dut[0].omem_flat, EXP_T1);

      // Second pass, started one cycle after returning to IDLE.
      clr[0] = 1'b1; @(negedge clk);
      clr[0] = 1'b0; start[0] = 1'b1; @(negedge clk);
      start[0] = 1'b0;

      for (int i = 0; i < 100 && !(g_dut[2].st.seen_done && !g_dut[2].bus.end_US); i++)
         @(negedge clk);
      check_run("t6_lat1", g_dut[1].st, 8, 42, 5);
      check_map("t6_lat1_map", g_dut[1].omem_flat, EXP_T1);
      check_run("t6_lat3", g_dut[2].st, 8, 46, 7);
      check_map("t6_lat3_map", g_dut[2].omem_flat, EXP_T1);

      for (int i = 0; i < 200 && !(g_dut[0].st.seen_done && !g_dut[0].bus.end_US); i++)
         @(negedge clk);
      check_run("t5_pass2", g_dut[0].st, 8, 44, 6);
      check_map("t5_pass2_map", g_dut[0].omem_flat, EXP_T1);

      // Extreme byte values must pass through untouched.
      tiny_in[0] = 8'h80; tiny_in[1] = 8'h7F; tiny_in[2] = 8'h00; tiny_in[3] = 8'hFF;
      tiny_in[4] = 8'hFF; tiny_in[5] = 8'h00; tiny_in[6] = 8'h7F; tiny_in[7] = 8'h80;
      clr[0] = 1'b1; @(negedge clk);
      clr[0] = 1'b0; start[0] = 1'b1; @(negedge clk);
      start[0] = 1'b0;
      for (int i = 0; i < 200 && !(g_dut[0].st.seen_done && !g_dut[0].bus.end_US); i++)
         @(negedge clk);
      check_run("t2", g_dut[0].st, 8, 44, 6);
      check_map("t2_map", g_dut[0].omem_flat, EXP_T2);

      // Default map: reset during WR_A of row 5 (output row 10, column 3).
      start[3] = 1'b1; @(negedge clk); start[3] = 1'b0;
      for (int i = 0; i < 2000 && !(g_dut[3].bus.ram_en && g_dut[3].bus.ram_addr_w == 16'd483);
           i++) @(negedge clk);
      check_eq("t4_row5_wr_a", g_dut[3].bus.ram_addr_w, 483);
      rst[3] = 1'b1; @(negedge clk); rst[3] = 1'b0;
      check_eq("t4_outs_after_rst", g_dut[3].outs, 0);
      @(negedge clk);
      check_eq("t4_idle_hold", g_dut[3].outs, 0);

      // Fresh start, full default run.
      clr[3] = 1'b1; @(negedge clk);
      clr[3] = 1'b0; start[3] = 1'b1; @(negedge clk);
      start[3] = 1'b0;
      for (int i = 0; i < 200 && !g_dut[3].bus.ram_en; i++) @(negedge clk);
      check_eq("t4_first_waddr", {g_dut[3].bus.ram_en, g_dut[3].bus.ram_addr_w}, 17'h10000);
      for (int i = 0; i < 30000 && !(g_dut[3].st.seen_done && !g_dut[3].bus.end_US); i++)
         @(negedge clk);
      check_run("t3", g_dut[3].st, 4608, 23424, 26);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
